// File: rtl/cpu_core_mc.sv
// cpu_core_mc: parametrised multicycle core (FETCH/EXEC/MEM/HALT) with
// req/ack instruction and data ports that tolerate wait-state memories.
module cpu_core_mc #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [DATA_W-1:0]  read_data,
    output logic [PC_W-1:0]    PC_out,
    output logic [DATA_W-1:0]  r7_data,
    output logic               retire,
    output logic               halted
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_BGTZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_regs [8];
    logic [DATA_W-1:0]   r_read_data;
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [DADDR_W-1:0]  r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_retire;
    logic                r_halted;

    logic [3:0]          w_op;
    logic [2:0]          w_rd;
    logic [2:0]          w_rs;
    logic [2:0]          w_rt;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_rs_val;
    logic [DATA_W-1:0]   w_rt_val;
    logic [DATA_W-1:0]   w_imm_d;
    logic [PC_W-1:0]     w_imm_pc;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_pc_next;
    logic [DATA_W-1:0]   w_alu;
    logic                w_wr_en;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:9];
    assign w_rs     = r_ir[8:6];
    assign w_rt     = r_ir[5:3];
    assign w_rd_val = r_regs[w_rd];
    assign w_rs_val = r_regs[w_rs];
    assign w_rt_val = r_regs[w_rt];
    // imm6 is sign-extended separately to data width and to PC width
    assign w_imm_d  = DATA_W'($signed(r_ir[5:0]));
    assign w_imm_pc = PC_W'($signed(r_ir[5:0]));
    assign w_pc_inc = r_pc + PC_W'(1);

    // Decode of single-cycle instructions: ALU result, write enable, next PC
    always_comb begin
        w_alu     = '0;
        w_wr_en   = 1'b0;
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_ADD:  begin w_alu = w_rs_val + w_rt_val; w_wr_en = 1'b1; end
            OP_SUB:  begin w_alu = w_rs_val - w_rt_val; w_wr_en = 1'b1; end
            OP_AND:  begin w_alu = w_rs_val & w_rt_val; w_wr_en = 1'b1; end
            OP_OR:   begin w_alu = w_rs_val | w_rt_val; w_wr_en = 1'b1; end
            OP_XOR:  begin w_alu = w_rs_val ^ w_rt_val; w_wr_en = 1'b1; end
            OP_ADDI: begin w_alu = w_rs_val + w_imm_d;  w_wr_en = 1'b1; end
            OP_BEQZ: if (w_rs_val == '0) w_pc_next = w_pc_inc + w_imm_pc;
            OP_BGTZ: if (!w_rs_val[DATA_W-1] && (w_rs_val != '0)) w_pc_next = w_pc_inc + w_imm_pc;
            OP_JMP:  w_pc_next = PC_W'(r_ir[11:0]);
            OP_HALT: w_pc_next = r_pc;
            default: ;
        endcase
    end

    // Main state machine; every output is a register so the ports are glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_read_data  <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // first cycle after reset raises the request; ack only counts while it is up
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_LW || w_op == OP_SW) begin
                        // address and store data use pre-instruction register values
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= (w_op == OP_SW);
                        r_dmem_addr  <= DADDR_W'(w_rs_val + w_imm_d);
                        r_dmem_wdata <= w_rd_val;
                        r_state      <= S_MEM;
                    end else if (w_op == OP_HALT) begin
                        r_retire <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        if (w_wr_en) r_regs[w_rd] <= w_alu;
                        r_pc       <= w_pc_next;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!r_dmem_we) begin
                            r_regs[w_rd] <= dmem_rdata;
                            r_read_data  <= dmem_rdata;
                        end
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign read_data  = r_read_data;
    assign PC_out     = r_pc;
    assign r7_data    = r_regs[7];
    assign retire     = r_retire;
    assign halted     = r_halted;
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: directed and random programs against an instruction-level
// reference model; memories with configurable wait states.
module tb_cpu_core_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, dmem_req, dmem_we, retire, halted;
    logic [7:0]  imem_addr, dmem_addr, PC_out;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_ack = 1'b0;
    logic [15:0] dmem_wdata, read_data, r7_data;
    logic [15:0] dmem_rdata = 16'h0;
    logic        dmem_ack = 1'b0;

    // second core with a 4-bit PC for the wrap test
    logic        reset4 = 1'b1;
    logic        imem_req4, dmem_req4, dmem_we4, retire4, halted4;
    logic [3:0]  imem_addr4, PC4;
    logic [15:0] imem_rdata4 = 16'h0;
    logic        imem_ack4 = 1'b0;
    logic [7:0]  dmem_addr4;
    logic [15:0] dmem_wdata4, read_data4, r7_4;
    logic [15:0] dmem_rdata4 = 16'h0;
    logic        dmem_ack4 = 1'b0;

    int checks = 0;
    int errors = 0;
    int i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
    bit stray = 1'b0;

    logic [15:0] imem [256];
    logic [15:0] rom4 [16];
    logic [15:0] dmem [256];
    logic [15:0] init_dmem [256];

    // reference model state
    logic [15:0] m_reg [8];
    logic [15:0] m_dmem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_rdv;
    bit          m_halt;

    // observations shared between run_prog and the directed steps
    logic [7:0]  fetch0_addr;
    logic [7:0]  st_addr;
    logic [15:0] st_data;
    bit          st_seen;

    cpu_core_mc #(.DATA_W(16), .PC_W(8), .DADDR_W(8)) u_dut (
        .clock(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .read_data(read_data), .PC_out(PC_out), .r7_data(r7_data), .retire(retire), .halted(halted)
    );

    cpu_core_mc #(.DATA_W(16), .PC_W(4), .DADDR_W(8)) u_dut4 (
        .clock(clk), .reset(reset4),
        .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4), .imem_ack(imem_ack4),
        .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_addr(dmem_addr4), .dmem_wdata(dmem_wdata4),
        .dmem_rdata(dmem_rdata4), .dmem_ack(dmem_ack4),
        .read_data(read_data4), .PC_out(PC4), .r7_data(r7_4), .retire(retire4), .halted(halted4)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    // memory responders: update just after the rising edge so the core samples them on the next one
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (i_cnt >= i_wait) begin
                imem_ack = 1'b1; imem_rdata = imem[imem_addr]; i_cnt = 0;
            end else begin
                imem_ack = 1'b0; imem_rdata = 16'($urandom); i_cnt++;
            end
        end else begin
            imem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 16'($urandom); i_cnt = 0;
        end
        if (dmem_req) begin
            if (d_cnt >= d_wait) begin
                dmem_ack = 1'b1; d_cnt = 0;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else dmem_rdata = dmem[dmem_addr];
            end else begin
                dmem_ack = 1'b0; dmem_rdata = 16'($urandom); d_cnt++;
            end
        end else begin
            dmem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata = 16'($urandom); d_cnt = 0;
        end
        imem_ack4 = imem_req4;
        imem_rdata4 = rom4[imem_addr4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input logic [5:0] imm);
        return {4'(op), 3'(rd), 3'(rs), imm};
    endfunction

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
    endfunction

    task automatic clear_imem();
        for (int a = 0; a < 256; a++) imem[a] = 16'hF000;
    endtask

    task automatic m_reset();
        for (int r = 0; r < 8; r++) m_reg[r] = 16'h0;
        for (int a = 0; a < 256; a++) begin dmem[a] = init_dmem[a]; m_dmem[a] = init_dmem[a]; end
        m_pc = 8'h0; m_rdv = 16'h0; m_halt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_reset();
        reset = 1'b0;
    endtask

    // Executes the instruction at m_pc and returns its expected cycle count
    task automatic m_step(output int lat);
        logic [15:0] ins, simm;
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        logic [7:0]  ea, nxt;
        ins = imem[m_pc];
        op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
        simm = {{10{ins[5]}}, ins[5:0]};
        nxt = m_pc + 8'd1;
        ea = 8'(m_reg[rs] + simm);
        lat = 2 + i_wait;
        case (op)
            4'h1: m_reg[rd] = m_reg[rs] + m_reg[rt];
            4'h2: m_reg[rd] = m_reg[rs] - m_reg[rt];
            4'h3: m_reg[rd] = m_reg[rs] & m_reg[rt];
            4'h4: m_reg[rd] = m_reg[rs] | m_reg[rt];
            4'h5: m_reg[rd] = m_reg[rs] ^ m_reg[rt];
            4'h6: m_reg[rd] = m_reg[rs] + simm;
            4'h7: begin m_rdv = m_dmem[ea]; m_reg[rd] = m_dmem[ea]; lat = 3 + i_wait + d_wait; end
            4'h8: begin m_dmem[ea] = m_reg[rd]; lat = 3 + i_wait + d_wait; end
            4'h9: if (m_reg[rs] == 16'h0) nxt = nxt + simm[7:0];
            4'hA: if ($signed(m_reg[rs]) > 0) nxt = nxt + simm[7:0];
            4'hB: nxt = ins[7:0];
            4'hF: begin nxt = m_pc; m_halt = 1'b1; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // Runs until halt (stop_ret==0) or stop_ret retirements; checks each retirement
    task automatic run_prog(input string name, input int stop_ret, output int n_ret, output int edges);
        int cyc, last_ret, first_ack, lat, dcnt;
        bit done, prev_ireq, prev_dreq, seen_req;
        logic [7:0]  prev_iaddr, frozen_pc;
        logic [24:0] d0;
        cyc = 0; last_ret = -1; first_ack = -1; dcnt = 0;
        done = 0; prev_ireq = 0; prev_dreq = 0; seen_req = 0; prev_iaddr = 8'h0;
        d0 = '0; n_ret = 0; edges = -1; st_seen = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (imem_req && !seen_req) begin fetch0_addr = imem_addr; seen_req = 1; end
            if (imem_req && prev_ireq) check({name, " iaddr_stable"}, imem_addr, prev_iaddr);
            if (imem_req && imem_ack && first_ack < 0) first_ack = cyc;
            prev_ireq = imem_req; prev_iaddr = imem_addr;
            if (dmem_req) begin
                if (!prev_dreq) begin
                    d0 = {dmem_we, dmem_addr, dmem_wdata}; dcnt = 1;
                    if (dmem_we) begin st_addr = dmem_addr; st_data = dmem_wdata; st_seen = 1; end
                end else begin
                    check({name, " dmem_stable"}, {dmem_we, dmem_addr, dmem_wdata}, d0);
                    dcnt++;
                end
            end else if (prev_dreq) begin
                check({name, " dreq_hold"}, dcnt, d_wait + 1);
            end
            prev_dreq = dmem_req;
            if (retire) begin
                m_step(lat);
                n_ret++;
                $display("%-10s ret#%0d pc=%02h r7=%04h rdata=%04h halted=%0b",
                         name, n_ret, PC_out, r7_data, read_data, halted);
                check({name, " r7"}, r7_data, m_reg[7]);
                check({name, " pc"}, PC_out, m_pc);
                check({name, " read_data"}, read_data, m_rdv);
                check({name, " halted"}, halted, m_halt);
                if (last_ret >= 0) check({name, " latency"}, cyc - last_ret, lat);
                last_ret = cyc;
                if (m_halt || (stop_ret > 0 && n_ret == stop_ret)) done = 1;
            end
        end
        check({name, " timeout"}, done, 1'b1);
        if (m_halt && done) begin
            // edges from the edge accepting the first fetch to the edge raising halted
            edges = cyc - first_ack - 1;
            frozen_pc = PC_out;
            repeat (3) begin
                @(negedge clk);
                check({name, " halt_idle"}, {imem_req, dmem_req, retire, halted, PC_out},
                      {4'b0001, frozen_pc});
            end
        end
    endtask

    int n_ret, edges, mism, len, k;
    logic [15:0] w;

    initial begin
        for (int a = 0; a < 256; a++) init_dmem[a] = 16'h0;
        for (int a = 0; a < 16; a++) rom4[a] = 16'h0000;
        rom4[0] = 16'hB00F;  // JMP 0xF, then NOP at 0xF wraps to 0

        // reset state
        clear_imem();
        repeat (2) @(negedge clk);
        check("reset_ctl", {imem_req, dmem_req, dmem_we, retire, halted}, 5'b0);
        check("reset_pc", PC_out, 8'h0);
        check("reset_r7", r7_data, 16'h0);
        check("reset_read_data", read_data, 16'h0);
        check("reset_daddr_wdata", {dmem_addr, dmem_wdata}, 24'h0);

        // program 1: ADDI r7,r0,5; ADDI r1,r0,3; ADD r7,r7,r1; HALT
        imem[0] = enc_i(6, 7, 0, 6'd5);
        imem[1] = enc_i(6, 1, 0, 6'd3);
        imem[2] = enc_r(1, 7, 7, 1);
        imem[3] = 16'hF000;

        // reset in the middle of a waiting fetch
        i_wait = 3; d_wait = 0;
        do_reset();
        k = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (imem_req && PC_out == 8'd1) begin k = 1; break; end
        end
        check("midfetch_found", k, 1);
        check("midfetch_pre_r7", r7_data, 16'd5);
        #2 reset = 1'b1;
        #1;
        check("midfetch_req", imem_req, 1'b0);
        check("midfetch_pc", PC_out, 8'h0);
        check("midfetch_r7", r7_data, 16'h0);
        @(negedge clk);
        m_reset();
        reset = 1'b0;
        run_prog("restart", 0, n_ret, edges);
        check("restart_fetch0", fetch0_addr, 8'h0);
        check("restart_r7", r7_data, 16'd8);

        // zero-wait run of program 1
        i_wait = 0;
        do_reset();
        run_prog("zerowait", 0, n_ret, edges);
        check("zw_r7", r7_data, 16'd8);
        check("zw_halted", halted, 1'b1);
        check("zw_pc", PC_out, 8'd3);
        check("zw_retires", n_ret, 4);
        check("zw_edges", edges, 7);

        // same program, three wait cycles on every fetch
        i_wait = 3;
        do_reset();
        run_prog("waitfetch", 0, n_ret, edges);
        check("wf_r7", r7_data, 16'd8);
        check("wf_retires", n_ret, 4);
        check("wf_edges", edges, 7 + 3 * 3);

        // load/store with a slow data memory
        clear_imem();
        imem[0] = enc_i(6, 1, 0, 6'h12);
        imem[1] = enc_i(8, 1, 0, 6'd4);
        imem[2] = enc_i(7, 7, 0, 6'd4);
        i_wait = 0; d_wait = 2;
        do_reset();
        run_prog("ldst", 0, n_ret, edges);
        check("ldst_store_seen", st_seen, 1'b1);
        check("ldst_store_addr", st_addr, 8'd4);
        check("ldst_store_data", st_data, 16'h12);
        check("ldst_read_data", read_data, 16'h12);
        check("ldst_r7", r7_data, 16'h12);

        // countdown loop then a taken BEQZ that skips one instruction
        clear_imem();
        imem[0] = enc_i(6, 1, 0, 6'd3);
        imem[1] = enc_i(6, 1, 1, 6'h3F);
        imem[2] = enc_i(10, 0, 1, 6'h3E);
        imem[3] = enc_i(9, 0, 1, 6'd1);
        imem[4] = enc_i(6, 7, 0, 6'd1);
        imem[5] = enc_i(6, 7, 1, 6'd2);
        d_wait = 0;
        do_reset();
        run_prog("branch", 0, n_ret, edges);
        check("br_retires", n_ret, 10);
        check("br_r7", r7_data, 16'd2);
        check("br_pc", PC_out, 8'd6);

        // BEQZ with offset -1 spins on itself
        clear_imem();
        imem[0] = enc_i(9, 0, 0, 6'h3F);
        do_reset();
        run_prog("selfloop", 3, n_ret, edges);
        check("selfloop_pc", PC_out, 8'h0);

        // 0x7FFF + 1 wraps to 0x8000
        clear_imem();
        init_dmem[0] = 16'h7FFF;
        imem[0] = enc_i(7, 7, 0, 6'd0);
        imem[1] = enc_i(6, 7, 7, 6'd1);
        do_reset();
        run_prog("overflow", 0, n_ret, edges);
        check("ovf_r7", r7_data, 16'h8000);

        // PC wrap on the 4-bit PC core
        @(negedge clk);
        reset4 = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 2; c++) begin
            @(negedge clk);
            if (retire4) begin
                k++;
                $display("pc4        ret#%0d pc=%0h", k, PC4);
                check("pc4_after_ret", PC4, (k == 1) ? 4'hF : 4'h0);
            end
        end
        check("pc4_retires", k, 2);

        // random forward-only programs with random wait states and stray acks
        stray = 1'b1;
        for (int p = 0; p < 8; p++) begin
            clear_imem();
            len = $urandom_range(12, 24);
            for (int a = 0; a < len; a++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: w = enc_r($urandom_range(1, 5), $urandom_range(0, 7),
                                       $urandom_range(0, 7), $urandom_range(0, 7));
                    3, 4:    w = enc_i(6, $urandom_range(0, 7), $urandom_range(0, 7), 6'($urandom));
                    5:       w = enc_i(7, $urandom_range(0, 7), $urandom_range(0, 7), 6'($urandom));
                    6:       w = enc_i(8, $urandom_range(0, 7), $urandom_range(0, 7), 6'($urandom));
                    7:       w = enc_i($urandom_range(9, 10), 0, $urandom_range(0, 7),
                                       6'($urandom_range(0, 3)));
                    8:       w = {4'hB, 12'(a + $urandom_range(1, 3))};
                    default: w = {4'($urandom_range(12, 14)), 12'($urandom)};
                endcase
                imem[a] = w;
            end
            for (int a = 0; a < 256; a++) init_dmem[a] = 16'($urandom);
            i_wait = $urandom_range(0, 3);
            d_wait = $urandom_range(0, 3);
            do_reset();
            run_prog($sformatf("rand%0d", p), 0, n_ret, edges);
            mism = 0;
            for (int a = 0; a < 256; a++) if (dmem[a] !== m_dmem[a]) mism++;
            check($sformatf("rand%0d dmem_image", p), mism, 0);
        end
        stray = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
